// File: rtl/srt_mul_check_if.sv
// Operand/result bundle for the Booth multiply-add checker.
// Handshake: START is sampled on a rising CLK edge only while BUSY is low;
// the edge that samples START=1 also latches A, B, C and EXP. DONE is a
// one-cycle pulse in which P and MATCH become valid; both then hold until
// the next DONE. There is no back-pressure on the result side.
interface srt_mul_check_if #(
   parameter int W = 64
);
   logic           START;
   logic [W-1:0]   A;
   logic [W-1:0]   B;
   logic [W-1:0]   C;
   logic [W-1:0]   EXP;
   logic           BUSY;
   logic           DONE;
   logic [2*W-1:0] P;
   logic           MATCH;

   modport master (
      output START, A, B, C, EXP,
      input  BUSY, DONE, P, MATCH
   );

   modport slave (
      input  START, A, B, C, EXP,
      output BUSY, DONE, P, MATCH
   );
endinterface

// File: rtl/srt_mul_check.sv
// Sequential radix-4 Booth multiply-add: P = A*B + C (unsigned), one Booth
// digit per clock. Used to rebuild a dividend from divisor, quotient and
// remainder and compare it with the expected value.
// W must be even and >= 4.
module srt_mul_check #(
   parameter int W = 64
) (
   input  logic             CLK,
   input  logic             RST,
   srt_mul_check_if.slave   bus,
   output logic [1:0]       state_o
);
   localparam int ND = W / 2 + 1;       // Booth digits over the W+2-bit multiplier
   localparam int CW = $clog2(ND);
   localparam int AW = 2 * W + 2;       // accumulator width, two's complement

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t          state_q;
   logic [W-1:0]    a_q;
   logic [W-1:0]    exp_q;
   logic [W+2:0]    mb_q;               // {00, B, b[-1]} shifted right two bits per digit
   logic [CW-1:0]   cnt_q;
   logic [AW-1:0]   acc_q;
   logic [AW-1:0]   acc_d;
   logic [AW-1:0]   pp;
   logic [AW-1:0]   a_ext;
   logic [2*W-1:0]  p_q;
   logic            match_q;
   logic            busy_q;
   logic            done_q;
   logic            last_digit;

   assign a_ext      = {{(AW - W){1'b0}}, a_q};
   assign last_digit = (cnt_q == CW'(ND - 1));

   // Booth digit select and accumulate of the shifted partial product.
   always_comb begin
      pp = '0;
      unique case (mb_q[2:0])
         3'b001, 3'b010: pp = a_ext;
         3'b011:         pp = a_ext << 1;
         3'b100:         pp = -(a_ext << 1);
         3'b101, 3'b110: pp = -a_ext;
         default:        pp = '0;
      endcase
      acc_d = acc_q + (pp << {cnt_q, 1'b0});
   end

   // Control FSM with datapath registers and registered outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         exp_q   <= '0;
         mb_q    <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         p_q     <= '0;
         match_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_FIN: begin
               // FIN accepts a new START just like IDLE, giving back-to-back issue.
               if (bus.START) begin
                  a_q     <= bus.A;
                  exp_q   <= bus.EXP;
                  acc_q   <= {{(AW - W){1'b0}}, bus.C};
                  mb_q    <= {2'b00, bus.B, 1'b0};
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               acc_q <= acc_d;
               mb_q  <= mb_q >> 2;
               cnt_q <= cnt_q + CW'(1);
               if (last_digit) begin
                  // Upper two accumulator bits are always zero here: no overflow.
                  p_q     <= acc_d[2*W-1:0];
                  match_q <= (acc_d[2*W-1:0] == {{W{1'b0}}, exp_q});
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_FIN;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.BUSY  = busy_q;
   assign bus.DONE  = done_q;
   assign bus.P     = p_q;
   assign bus.MATCH = match_q;
   assign state_o   = state_q;
endmodule

// File: tb/tb_srt_mul_check.sv
// Directed self-checking bench for srt_mul_check (W=64).
module tb_srt_mul_check;
   localparam int W  = 64;
   localparam int ND = W / 2 + 1;

   logic       CLK = 1'b0;
   logic       RST;
   logic [1:0] state_dbg;

   int checks = 0;
   int errors = 0;

   srt_mul_check_if #(.W(W)) bus ();

   srt_mul_check #(.W(W)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .bus     (bus),
      .state_o (state_dbg)
   );

   // Clock
   always #5 CLK = ~CLK;

   // Driver: present operands with START for one accept edge, sample #1 after.
   task automatic launch(input logic [W-1:0] a, b, c, e);
      @(negedge CLK);
      bus.A = a; bus.B = b; bus.C = c; bus.EXP = e;
      bus.START = 1'b1;
      @(posedge CLK); #1;
      bus.START = 1'b0;
   endtask

   // Count cycles until DONE is seen (bounded at 100).
   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         @(posedge CLK); #1;
         cyc++;
      end while (!bus.DONE && cyc < 100);
   endtask

   task automatic test_reset();
      checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
      checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.DONE); end
      checks++; if (bus.P !== '0) begin errors++; $display("FAIL reset_p: got %h want 0", bus.P); end
      checks++; if (bus.MATCH !== 1'b0) begin errors++; $display("FAIL reset_match: got %b want 0", bus.MATCH); end
      checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
   endtask

   task automatic test_basic();
      int cyc;
      int busy_bad;
      launch(64'd21, 64'd3, 64'd11, 64'd74);
      checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL basic_busy_start: got %b want 1", bus.BUSY); end
      cyc = 0; busy_bad = 0;
      do begin
         @(posedge CLK); #1;
         cyc++;
         if (!bus.DONE && bus.BUSY !== 1'b1) busy_bad++;
      end while (!bus.DONE && cyc < 100);
      checks++; if (cyc != ND) begin errors++; $display("FAIL basic_latency: got %0d want %0d", cyc, ND); end
      checks++; if (busy_bad != 0) begin errors++; $display("FAIL basic_busy_run: got %0d low cycles want 0", busy_bad); end
      checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b want 0", bus.BUSY); end
      checks++; if (bus.P !== 128'd74) begin errors++; $display("FAIL basic_p: got %h want 74", bus.P); end
      checks++; if (bus.MATCH !== 1'b1) begin errors++; $display("FAIL basic_match: got %b want 1", bus.MATCH); end
      @(posedge CLK); #1;
      checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", bus.DONE); end
      checks++; if (bus.P !== 128'd74) begin errors++; $display("FAIL basic_p_hold: got %h want 74", bus.P); end
      checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL basic_idle: got %0d want 0", state_dbg); end
   endtask

   task automatic test_all_ones();
      int cyc;
      launch({W{1'b1}}, {W{1'b1}}, {W{1'b1}}, 64'd0);
      wait_done(cyc);
      checks++; if (cyc != ND) begin errors++; $display("FAIL ones_latency: got %0d want %0d", cyc, ND); end
      checks++; if (bus.P !== 128'hFFFFFFFFFFFFFFFF0000000000000000) begin errors++; $display("FAIL ones_p: got %h want ffffffffffffffff0000000000000000", bus.P); end
      checks++; if (bus.MATCH !== 1'b0) begin errors++; $display("FAIL ones_match: got %b want 0", bus.MATCH); end
   endtask

   task automatic test_alternating();
      int cyc;
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] prod;
      a = 64'h123456789ABCDEF0;
      b = 64'hAAAAAAAAAAAAAAAA;
      prod = {64'd0, a} * {64'd0, b};
      // Low half as EXP: high half is nonzero, so MATCH must still be 0.
      launch(a, b, 64'd0, prod[W-1:0]);
      wait_done(cyc);
      checks++; if (cyc != ND) begin errors++; $display("FAIL alt_latency: got %0d want %0d", cyc, ND); end
      checks++; if (bus.P !== prod) begin errors++; $display("FAIL alt_p: got %h want %h", bus.P, prod); end
      checks++; if (bus.MATCH !== 1'b0) begin errors++; $display("FAIL alt_match: got %b want 0", bus.MATCH); end
   endtask

   task automatic test_ignore_start();
      int dones;
      logic [2*W-1:0] first_p;
      logic           first_m;
      launch(64'd1000, 64'd7, 64'd3, 64'd7003);
      repeat (9) @(posedge CLK);
      @(negedge CLK);
      bus.A = 64'd55; bus.B = 64'd66; bus.C = 64'd77; bus.EXP = 64'd0;
      bus.START = 1'b1;
      @(posedge CLK); #1;
      bus.START = 1'b0;
      dones = 0; first_p = '0; first_m = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge CLK); #1;
         if (bus.DONE) begin
            if (dones == 0) begin first_p = bus.P; first_m = bus.MATCH; end
            dones++;
         end
      end
      checks++; if (dones != 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
      checks++; if (first_p !== 128'd7003) begin errors++; $display("FAIL ignore_p: got %h want 7003", first_p); end
      checks++; if (first_m !== 1'b1) begin errors++; $display("FAIL ignore_match: got %b want 1", first_m); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      @(negedge CLK);
      bus.A = 64'd5; bus.B = 64'd6; bus.C = 64'd7; bus.EXP = 64'd37;
      bus.START = 1'b1;
      @(posedge CLK); #1;
      wait_done(cyc);
      checks++; if (bus.P !== 128'd37) begin errors++; $display("FAIL b2b_p1: got %h want 37", bus.P); end
      // New operands in the FIN cycle with START still high.
      bus.A = 64'd9; bus.B = 64'd9; bus.C = 64'd0; bus.EXP = 64'd81;
      @(posedge CLK); #1;
      checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b want 1", bus.BUSY); end
      bus.START = 1'b0;
      wait_done(cyc);
      cyc = cyc + 1;
      checks++; if (cyc != ND + 1) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", cyc, ND + 1); end
      checks++; if (bus.P !== 128'd81) begin errors++; $display("FAIL b2b_p2: got %h want 81", bus.P); end
      checks++; if (bus.MATCH !== 1'b1) begin errors++; $display("FAIL b2b_match: got %b want 1", bus.MATCH); end
   endtask

   task automatic test_reset_mid_run();
      int cyc;
      int dones;
      launch({W{1'b1}}, {W{1'b1}}, 64'd1, 64'd0);
      repeat (14) @(posedge CLK);
      #3 RST = 1'b1;
      #1;
      checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.BUSY); end
      checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus.DONE); end
      checks++; if (bus.P !== '0) begin errors++; $display("FAIL rst_p: got %h want 0", bus.P); end
      checks++; if (bus.MATCH !== 1'b0) begin errors++; $display("FAIL rst_match: got %b want 0", bus.MATCH); end
      @(negedge CLK);
      RST = 1'b0;
      dones = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge CLK); #1;
         if (bus.DONE) dones++;
      end
      checks++; if (dones != 0) begin errors++; $display("FAIL rst_no_done: got %0d want 0", dones); end
      launch(64'd123, 64'd0, 64'd5, 64'd5);
      wait_done(cyc);
      checks++; if (cyc != ND) begin errors++; $display("FAIL rst_after_latency: got %0d want %0d", cyc, ND); end
      checks++; if (bus.P !== 128'd5) begin errors++; $display("FAIL rst_after_p: got %h want 5", bus.P); end
      checks++; if (bus.MATCH !== 1'b1) begin errors++; $display("FAIL rst_after_match: got %b want 1", bus.MATCH); end
   endtask

   initial begin
      RST = 1'b1;
      bus.START = 1'b0;
      bus.A = '0; bus.B = '0; bus.C = '0; bus.EXP = '0;
      repeat (3) @(posedge CLK);
      #1;
      test_reset();
      @(negedge CLK);
      RST = 1'b0;
      test_basic();
      test_all_ones();
      test_alternating();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
